mem_port_unit: RTL and testbench
================================

Name: mem_port_unit

Overview:
- Memory front-end for the multicycle CPU, directly downstream of the control FSM.
- Consumes the control FSM's IorD, MemWrite and IRWrite and runs one access per request on a unified instruction/data memory with variable latency.
- Holds the Instruction Register (IR) and the Memory Data Register (MDR).
- Drives Op/Funct back to the control FSM, plus a stall that freezes the FSM until the access completes.

Parameters:
ADDR_W, 32, byte-address width of pc/alu_out
DATA_W, 32, data/instruction width
TIMEOUT, 64, max cycles waiting for mem_ack before abort (range 2..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pc  in  ADDR_W  program counter (byte address)
alu_out  in  ADDR_W  ALUOut register (byte address for lw/sw)
wdata  in  DATA_W  B register, store data
IorD  in  1  0: address=pc, 1: address=alu_out
MemWrite  in  1  store request
IRWrite  in  1  instruction fetch request
mem_req  out  1  memory request, held until ack
mem_we  out  1  write enable, valid with mem_req
mem_addr  out  ADDR_W-2  word address
mem_wdata  out  DATA_W  store data
mem_ack  in  1  one-cycle completion; mem_rdata valid same cycle
mem_rdata  in  DATA_W  read data
instr  out  DATA_W  IR contents
Op  out  6  instr[31:26]
Funct  out  6  instr[5:0]
mdr  out  DATA_W  MDR contents
stall  out  1  control FSM must hold state while high
err  out  1  one-cycle pulse: misaligned or timeout

Behaviour:
- Reset (async, rst_n low): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr=0 (NOP), mdr=0, stall=0, err=0, serviced=0, timeout counter=0. Reset mid-access drops mem_req immediately; any ack after reset is ignored.
- Request kind (combinational from inputs):
  - FETCH if IRWrite.
  - STORE else if MemWrite.
  - LOAD else if IorD.
  - NONE otherwise.
- Access address: alu_out if IorD, else pc.
- serviced flag: set when an access completes or aborts; cleared when kind is NONE or kind differs from the last serviced kind. Prevents re-issue while the control FSM holds its signals over several cycles.
- stall = (kind != NONE && !serviced && state==IDLE) || state==WAIT. It is combinational, so the FSM sees it in the same cycle the request appears.
- FSM states: IDLE, WAIT.
- IDLE, kind!=NONE, !serviced:
  - If address[1:0]!=0: err=1 for one cycle, serviced=1, no memory request, stay IDLE.
  - Otherwise, next cycle: mem_req=1, mem_we=(kind==STORE), mem_addr=address[ADDR_W-1:2], mem_wdata=wdata. Request fields are registered and held stable. Counter=0. Go to WAIT.
- WAIT, mem_ack=1:
  - FETCH: instr<=mem_rdata.
  - LOAD: mdr<=mem_rdata.
  - STORE: no register update.
  - Then mem_req=0, serviced=1, go to IDLE. stall drops the cycle after ack.
  - Minimum latency, request to stall low: 2 cycles (ack on first WAIT cycle).
- WAIT, no ack: counter+1. When counter reaches TIMEOUT-1 without ack: mem_req=0, err pulse, serviced=1, go to IDLE. instr/mdr unchanged.
- Input changes while in WAIT are ignored; the latched request completes.
- mem_ack in IDLE is ignored.
- Op/Funct are pure slices of instr.
- Back-to-back: a new kind in the cycle after completion starts a new access. There is no idle gap beyond the IDLE→WAIT transition.

Decomposition:
- Shared package cpu_pkg: opcode constants (LW=6'b100011, SW=6'b101011, R_type=0, BGTZ=6'b000111, ADDI=6'b001000, JUMP=6'b000010), access-kind enum (NONE/FETCH/LOAD/STORE), NOP instruction constant.
- One sub-module, mem_timeout_cnt: loadable counter with terminal flag, parameterised by TIMEOUT.
- FSM, IR and MDR stay in the top module.

Test Plan:
- Fetch: pc=0x00000010, IRWrite=1, memory acks after 3 cycles with 0x8C220004 -> mem_addr=0x4, mem_we=0; stall high for 4 cycles; instr=0x8C220004; Op=6'b100011.
- Load: IorD=1, alu_out=0x20, 0-wait ack, rdata=0xDEADBEEF -> mdr=0xDEADBEEF; instr unchanged; exactly one mem_req while IorD is held 3 cycles.
- Store: IorD=1, MemWrite=1, alu_out=0x44, wdata=0x12345678 -> mem_we=1, mem_addr=0x11, mem_wdata=0x12345678; mdr unchanged.
- Misaligned: alu_out=0x22, IorD=1 -> err pulse, mem_req never asserted, stall high for 1 cycle only.
- Timeout: TIMEOUT=8, fetch with no ack -> mem_req high 8 cycles then low; err pulse; instr keeps its previous value; stall low afterwards.
- Reset mid-WAIT: assert rst_n=0 two cycles into a fetch -> mem_req=0 and instr=0 immediately; a late ack after release is ignored; a new fetch proceeds normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multicycle CPU datapath blocks: MIPS opcode
// constants, the memory access-kind enumeration, the memory port FSM states
// and the NOP instruction word.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_JUMP   = 6'b000010;

  // sll $0,$0,0 -- the IR contents after reset
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_FETCH = 2'd1,
    KIND_LOAD  = 2'd2,
    KIND_STORE = 2'd3
  } access_kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } port_state_e;

  // Fetch has priority over store, store over load.
  function automatic access_kind_e decode_kind(input logic irwrite,
                                               input logic memwrite,
                                               input logic iord);
    access_kind_e kind;
    if (irwrite) begin
      kind = KIND_FETCH;
    end else if (memwrite) begin
      kind = KIND_STORE;
    end else if (iord) begin
      kind = KIND_LOAD;
    end else begin
      kind = KIND_NONE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// -----------------------------------------------------------------------------
// mem_timeout_cnt
// Clearable up-counter with a terminal flag, used to bound the number of
// cycles the memory port waits for an acknowledge.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : load the counter with zero (priority over en_i)
//   en_i       : increment by one
//   term_o     : counter currently holds TIMEOUT-1
// -----------------------------------------------------------------------------
module mem_timeout_cnt #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_unit.sv
// -----------------------------------------------------------------------------
// mem_port_unit
// Memory front-end of the multicycle CPU. Turns the control FSM's
// IorD/MemWrite/IRWrite into single accesses on a variable-latency unified
// memory, holds the IR and MDR, and stalls the control FSM until the access
// finishes.
//   Control side : pc, alu_out, wdata, IorD, MemWrite, IRWrite in;
//                  Op, Funct, stall, err out
//   Memory side  : mem_req, mem_we, mem_addr (word), mem_wdata out;
//                  mem_ack, mem_rdata in
//   Registers    : instr (IR), mdr (MDR)
// -----------------------------------------------------------------------------
module mem_port_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  input  logic              IorD,
  input  logic              MemWrite,
  input  logic              IRWrite,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        Op,
  output logic [5:0]        Funct,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              err
);

  port_state_e       state_q,     state_d;
  access_kind_e      req_kind_q,  req_kind_d;
  access_kind_e      last_kind_q, last_kind_d;
  logic              serviced_q,  serviced_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] instr_q,     instr_d;
  logic [DATA_W-1:0] mdr_q,       mdr_d;
  logic              err_q,       err_d;

  access_kind_e      kind_s;
  logic [ADDR_W-1:0] addr_s;
  logic              done_s;
  logic              cnt_clr_s;
  logic              cnt_en_s;
  logic              cnt_term_s;

  assign kind_s = decode_kind(IRWrite, MemWrite, IorD);
  assign addr_s = IorD ? alu_out : pc;

  // The control FSM holds its strobes for several cycles; a request counts as
  // already done only while the same kind stays asserted.
  assign done_s = serviced_q && (kind_s == last_kind_q);

  assign stall = ((kind_s != KIND_NONE) && !done_s && (state_q == ST_IDLE)) ||
                 (state_q == ST_WAIT);

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .term_o (cnt_term_s)
  );

  // Access FSM: issue, wait for ack or timeout, capture IR/MDR.
  always_comb begin
    state_d     = state_q;
    req_kind_d  = req_kind_q;
    last_kind_d = last_kind_q;
    serviced_d  = serviced_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    instr_d     = instr_q;
    mdr_d       = mdr_q;
    err_d       = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_en_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (kind_s == KIND_NONE) begin
          serviced_d = 1'b0;
        end else if (!done_s) begin
          if (addr_s[1:0] != 2'b00) begin
            // Misaligned: reject without touching memory.
            err_d       = 1'b1;
            serviced_d  = 1'b1;
            last_kind_d = kind_s;
          end else begin
            state_d     = ST_WAIT;
            req_kind_d  = kind_s;
            serviced_d  = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = (kind_s == KIND_STORE);
            mem_addr_d  = addr_s[ADDR_W-1:2];
            mem_wdata_d = wdata;
            cnt_clr_s   = 1'b1;
          end
        end else begin
          serviced_d = serviced_q;
        end
      end

      ST_WAIT: begin
        if (mem_ack) begin
          case (req_kind_q)
            KIND_FETCH: instr_d = mem_rdata;
            KIND_LOAD:  mdr_d   = mem_rdata;
            default:    instr_d = instr_q;
          endcase
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          serviced_d  = 1'b1;
          last_kind_d = req_kind_q;
        end else if (cnt_term_s) begin
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          err_d       = 1'b1;
          serviced_d  = 1'b1;
          last_kind_d = req_kind_q;
        end else begin
          cnt_en_s = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_kind_q  <= KIND_NONE;
      last_kind_q <= KIND_NONE;
      serviced_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {(ADDR_W-2){1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      instr_q     <= DATA_W'(NOP_INSTR);
      mdr_q       <= {DATA_W{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_kind_q  <= req_kind_d;
      last_kind_q <= last_kind_d;
      serviced_q  <= serviced_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      instr_q     <= instr_d;
      mdr_q       <= mdr_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign instr     = instr_q;
  assign mdr       = mdr_q;
  assign err       = err_q;
  assign Op        = instr_q[31:26];
  assign Funct     = instr_q[5:0];

endmodule

// File: tb/tb_mem_port_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_port_unit
// Directed scenarios for mem_port_unit with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 1 time unit later.
// -----------------------------------------------------------------------------
module tb_mem_port_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, alu_out, wdata;
  logic        IorD, MemWrite, IRWrite;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [5:0]  Op, Funct;
  logic [31:0] mdr;
  logic        stall, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_unit #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .alu_out   (alu_out),
    .wdata     (wdata),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .instr     (instr),
    .Op        (Op),
    .Funct     (Funct),
    .mdr       (mdr),
    .stall     (stall),
    .err       (err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    mem_ack  = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
  endtask

  // Runs ncyc cycles with the current request inputs held; pulses mem_ack on
  // cycle ack_at (-1 = never). Counts cycles with stall/mem_req/err high and
  // records the request fields seen while mem_req was high.
  task automatic run_cycles(input int ncyc, input int ack_at,
                            input logic [31:0] rdata,
                            output int stall_n, output int req_n,
                            output int err_n, output logic [29:0] addr_seen,
                            output logic we_seen, output logic [31:0] wdata_seen);
    stall_n = 0; req_n = 0; err_n = 0;
    addr_seen = 30'h3FFF_FFFF; we_seen = 1'bx; wdata_seen = 32'hFFFF_FFFF;
    for (int c = 0; c < ncyc; c++) begin
      mem_ack   = (c == ack_at);
      mem_rdata = (c == ack_at) ? rdata : 32'hBAD0_BAD0;
      #1;
      if (stall)   stall_n++;
      if (err)     err_n++;
      if (mem_req) begin
        req_n++;
        addr_seen  = mem_addr;
        we_seen    = mem_we;
        wdata_seen = mem_wdata;
      end
      @(posedge clk);
      #1;
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pc = 32'h0; alu_out = 32'h0; wdata = 32'h0;
    idle_inputs();
    #2;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, instr, mdr, stall, err} !== 98'h0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b we=%b addr=%h wd=%h instr=%h mdr=%h stall=%b err=%b exp all zero",
               mem_req, mem_we, mem_addr, mem_wdata, instr, mdr, stall, err);
    end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_fetch();
    int sn, rn, en; logic [29:0] a; logic w; logic [31:0] d;
    pc = 32'h0000_0010; IRWrite = 1'b1;
    run_cycles(6, 3, 32'h8C22_0004, sn, rn, en, a, w, d);
    checks++;
    if (a !== 30'h4 || w !== 1'b0) begin
      failures++; $display("FAIL fetch_req got addr=%h we=%b exp addr=4 we=0", a, w);
    end
    checks++;
    if (sn !== 4) begin failures++; $display("FAIL fetch_stall got=%0d exp=4", sn); end
    checks++;
    if (instr !== 32'h8C22_0004 || Op !== 6'b100011 || Funct !== 6'b000100) begin
      failures++; $display("FAIL fetch_ir got instr=%h Op=%b Funct=%b exp 8c220004/100011/000100", instr, Op, Funct);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_load();
    int sn, rn, en; logic [29:0] a; logic w; logic [31:0] d;
    alu_out = 32'h0000_0020; IorD = 1'b1;
    run_cycles(3, 1, 32'hDEAD_BEEF, sn, rn, en, a, w, d);
    checks++;
    if (mdr !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_mdr got=%h exp=deadbeef", mdr); end
    checks++;
    if (instr !== 32'h8C22_0004) begin failures++; $display("FAIL load_ir_kept got=%h exp=8c220004", instr); end
    checks++;
    if (rn !== 1 || sn !== 2 || a !== 30'h8 || w !== 1'b0) begin
      failures++; $display("FAIL load_single_req got req=%0d stall=%0d addr=%h we=%b exp 1/2/8/0", rn, sn, a, w);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_store();
    int sn, rn, en; logic [29:0] a; logic w; logic [31:0] d;
    alu_out = 32'h0000_0044; wdata = 32'h1234_5678; IorD = 1'b1; MemWrite = 1'b1;
    run_cycles(4, 2, 32'hCAFE_F00D, sn, rn, en, a, w, d);
    checks++;
    if (w !== 1'b1 || a !== 30'h11 || d !== 32'h1234_5678) begin
      failures++; $display("FAIL store_req got we=%b addr=%h wd=%h exp 1/11/12345678", w, a, d);
    end
    checks++;
    if (mdr !== 32'hDEAD_BEEF || instr !== 32'h8C22_0004) begin
      failures++; $display("FAIL store_regs_kept got mdr=%h instr=%h exp deadbeef/8c220004", mdr, instr);
    end
    checks++;
    if (sn !== 3 || rn !== 2) begin failures++; $display("FAIL store_timing got stall=%0d req=%0d exp 3/2", sn, rn); end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_misaligned();
    int sn, rn, en; logic [29:0] a; logic w; logic [31:0] d;
    alu_out = 32'h0000_0022; IorD = 1'b1;
    run_cycles(4, -1, 32'h0, sn, rn, en, a, w, d);
    checks++;
    if (en !== 1) begin failures++; $display("FAIL misalign_err got=%0d exp=1", en); end
    checks++;
    if (rn !== 0) begin failures++; $display("FAIL misalign_noreq got=%0d exp=0", rn); end
    checks++;
    if (sn !== 1) begin failures++; $display("FAIL misalign_stall got=%0d exp=1", sn); end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_timeout();
    int sn, rn, en; logic [29:0] a; logic w; logic [31:0] d;
    pc = 32'h0000_0030; IRWrite = 1'b1;
    run_cycles(14, -1, 32'h0, sn, rn, en, a, w, d);
    checks++;
    if (rn !== 8) begin failures++; $display("FAIL timeout_req_len got=%0d exp=8", rn); end
    checks++;
    if (en !== 1) begin failures++; $display("FAIL timeout_err got=%0d exp=1", en); end
    checks++;
    if (instr !== 32'h8C22_0004 || stall !== 1'b0 || sn !== 9) begin
      failures++; $display("FAIL timeout_after got instr=%h stall=%b stall_cycles=%0d exp 8c220004/0/9", instr, stall, sn);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    int sn, rn, en; logic [29:0] a; logic w; logic [31:0] d;
    pc = 32'h0000_0040; IRWrite = 1'b1;
    run_cycles(3, -1, 32'h0, sn, rn, en, a, w, d);
    checks++;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_pre_req got=%b exp=1", mem_req); end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr !== 32'h0 || stall !== 1'b0) begin
      failures++; $display("FAIL rstmid_async got req=%b instr=%h stall=%b exp 0/0/0", mem_req, instr, stall);
    end
    next_cycle();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (instr !== 32'h0 || mem_req !== 1'b0 || mdr !== 32'h0) begin
      failures++; $display("FAIL rstmid_late_ack got instr=%h req=%b mdr=%h exp 0/0/0", instr, mem_req, mdr);
    end
    pc = 32'h0000_0050; IRWrite = 1'b1;
    run_cycles(3, 1, 32'h2001_0005, sn, rn, en, a, w, d);
    checks++;
    if (instr !== 32'h2001_0005 || Op !== 6'b001000 || a !== 30'h14 || sn !== 2) begin
      failures++; $display("FAIL rstmid_refetch got instr=%h Op=%b addr=%h stall=%0d exp 20010005/001000/14/2", instr, Op, a, sn);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int sn, rn, en; logic [29:0] a; logic w; logic [31:0] d;
    pc = 32'h0000_0060; IRWrite = 1'b1;
    run_cycles(2, 1, 32'h00A0_1020, sn, rn, en, a, w, d);
    IRWrite = 1'b0; IorD = 1'b1; alu_out = 32'h0000_0080;
    run_cycles(3, 1, 32'h55AA_55AA, sn, rn, en, a, w, d);
    checks++;
    if (instr !== 32'h00A0_1020 || Op !== 6'b000000 || Funct !== 6'b100000) begin
      failures++; $display("FAIL b2b_fetch got instr=%h Op=%b Funct=%b exp 00a01020/000000/100000", instr, Op, Funct);
    end
    checks++;
    if (mdr !== 32'h55AA_55AA || a !== 30'h20 || rn !== 1 || sn !== 2) begin
      failures++; $display("FAIL b2b_load got mdr=%h addr=%h req=%0d stall=%0d exp 55aa55aa/20/1/2", mdr, a, rn, sn);
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
